// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), one SLICE-bit slice per clock.
// Optional `SEQ_LOGIC_ZERO_FLAG_EN adds a registered result-is-zero output.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SLICE-1:0]   sel_a, sel_b, slice_res;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  // Operand slice selected by the current slice counter
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sel_a = a_q[i*SLICE +: SLICE];
        sel_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    unique case (op_q)
      2'b00:   slice_res = sel_a & sel_b;
      2'b01:   slice_res = sel_a | sel_b;
      2'b10:   slice_res = sel_a ^ sel_b;
      default: slice_res = ~(sel_a | sel_b);
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
          zero_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            result_d[i*SLICE +: SLICE] = slice_res;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Bench for seq_logic_unit: directed table, reset/busy corner cases, random ops vs. model.
// Zero-flag checks are active when SEQ_LOGIC_ZERO_FLAG_EN is defined.
module tb_seq_logic_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned SL = 8;
  localparam int unsigned NS = W / SL;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, start1;
  logic [1:0]    op, op1;
  logic [W-1:0]  a, b, a1, b1;
  logic          busy, done, busy1, done1;
  logic [W-1:0]  result, result1;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
  logic          zero, zero1;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] held_res;
  logic         zexp;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(W), .SLICE(SL)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  seq_logic_unit #(.WIDTH(W), .SLICE(W)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1)
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    , .zero(zero1)
`endif
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic [W-1:0] low_mask(input int k);
    logic [63:0] m;
    m = (64'd1 << (k * SL)) - 64'd1;
    return m[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation on the N=4 unit; returns at the cycle where done is expected
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] ex, input bit noise);
    start = 1'b1; op = o; a = aa; b = bb;
    tick();
    chk("accept_busy", W'(busy), W'(1));
    chk("accept_done", W'(done), W'(0));
    chk("accept_result", result, '0);
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    chk("accept_zero", W'(zero), W'(0));
`endif
    for (int k = 1; k <= int'(NS); k++) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("run_result", result, ex & low_mask(k));
      chk("run_busy", W'(busy), W'(k < int'(NS)));
      chk("run_done", W'(done), W'(k == int'(NS)));
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
      chk("run_zero", W'(zero), W'((k == int'(NS)) && (ex == '0)));
`endif
    end
    start = 1'b0;
    held_res = ex;
    zexp = (ex == '0);
  endtask

  task automatic idle_check;
    start = 1'b0;
    tick();
    chk("idle_busy", W'(busy), W'(0));
    chk("idle_done", W'(done), W'(0));
    chk("idle_result", result, held_res);
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    chk("idle_zero", W'(zero), W'(zexp));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, rex;
    bit           b2b;

    vecs[0] = '{2'b01, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF};
    vecs[1] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[2] = '{2'b10, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000};
    vecs[5] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};

    start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    held_res = '0; zexp = 1'b0;

    // Reset with start held high: must stay idle
    reset = 1'b1; start = 1'b1; op = 2'b11; a = $urandom; b = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_result", result, '0);
      chk("rst1_result", result1, '0);
    end
    reset = 1'b0;
    idle_check();

    // Directed table, all back-to-back, start pulsed while busy
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    end
    idle_check();
    idle_check();

    // Reset mid-operation aborts with no done pulse
    start = 1'b1; op = 2'b10; a = 32'h1234_5678; b = 32'hFFFF_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_result", result, '0);
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    chk("abort_zero", W'(zero), W'(0));
`endif
    reset = 1'b0;
    held_res = '0; zexp = 1'b0;
    for (int i = 0; i < 4; i++) idle_check();
    run_op(2'b01, 32'h1, 32'h2, 32'h3, 1'b0);
    idle_check();

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      if ((i % 7) == 0) rb = ra;
      rex = model(ro, ra, rb);
      run_op(ro, ra, rb, rex, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    // SLICE == WIDTH instance: done one clock after accept
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      if (i == 0) begin ro = 2'b00; ra = 32'hAAAA_AAAA; rb = 32'h5555_5555; end
      rex = model(ro, ra, rb);
      b2b = bit'($urandom_range(0, 1));
      start1 = 1'b1; op1 = ro; a1 = ra; b1 = rb;
      tick();
      chk("s1_accept_busy", W'(busy1), W'(1));
      chk("s1_accept_done", W'(done1), W'(0));
      chk("s1_accept_result", result1, '0);
      start1 = 1'b0; a1 = $urandom; b1 = $urandom; op1 = 2'($urandom);
      tick();
      chk("s1_done", W'(done1), W'(1));
      chk("s1_busy", W'(busy1), W'(0));
      chk("s1_result", result1, rex);
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
      chk("s1_zero", W'(zero1), W'(rex == '0));
`endif
      if (!b2b) begin
        tick();
        chk("s1_idle_done", W'(done1), W'(0));
        chk("s1_idle_result", result1, rex);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
